fp_normalize: RTL

FP_NORMALIZE -- requirements
Module: fp_normalize

---
 rtl/fp_normalize.sv | 115 +++++++++++
 1 files changed

// File: rtl/fp_normalize.sv
// Post-add normalizer for IEEE-754 single precision: carry/left-shift normalize, optional RNE rounding.
// Build option: define FP_NORM_ROUND_EN to include the ROUND state; otherwise G/R/S are truncated.
module fp_normalize (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [27:0] in_mant,
   input  logic [7:0]  in_exp,
   input  logic        in_sign,
   output logic [23:0] mant_norm,
   output logic [7:0]  exp_norm,
   output logic        sign_res,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   state_t      state_q, state_d;
   logic [27:0] wm_q, wm_d;
   logic [8:0]  we_q, we_d;
   logic        ws_q, ws_d;
   logic        rnd;
   logic [24:0] sum;

`ifdef FP_NORM_ROUND_EN
   localparam state_t POST = ROUND;
`else
   localparam state_t POST = DONE;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wm_q    <= '0;
         we_q    <= '0;
         ws_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wm_q    <= wm_d;
         we_q    <= we_d;
         ws_q    <= ws_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wm_d    = wm_q;
      we_d    = we_q;
      ws_d    = ws_q;
      rnd     = wm_q[2] & (wm_q[1] | wm_q[0] | wm_q[3]);
      sum     = {1'b0, wm_q[26:3]} + {24'd0, rnd};
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               wm_d    = in_mant;
               we_d    = {1'b0, in_exp};
               ws_d    = in_sign;
               state_d = NORM;
            end
         end
         NORM: begin
            if (we_q == 9'h0FF) begin
               wm_d    = '0;
               state_d = DONE;
            end else if (wm_q == 28'd0) begin
               we_d    = '0;
               state_d = DONE;
            end else if (wm_q[27]) begin
               // Dropped LSB folds into sticky so rounding still sees it.
               wm_d = {1'b0, wm_q[27:2], wm_q[1] | wm_q[0]};
               we_d = we_q + 9'd1;
               if (we_d >= 9'h0FF) begin
                  wm_d    = '0;
                  state_d = DONE;
               end else begin
                  state_d = POST;
               end
            end else if (wm_q[26]) begin
               state_d = POST;
            end else if (we_q <= 9'd1) begin
               wm_d    = '0;
               we_d    = '0;
               state_d = DONE;
            end else begin
               wm_d = {wm_q[26:0], 1'b0};
               we_d = we_q - 9'd1;
            end
         end
`ifdef FP_NORM_ROUND_EN
         ROUND: begin
            if (sum[24]) begin
               we_d = we_q + 9'd1;
               wm_d = (we_d >= 9'h0FF) ? 28'd0 : {1'b0, 24'h800000, 3'b000};
            end else begin
               wm_d = {1'b0, sum[23:0], 3'b000};
            end
            state_d = DONE;
         end
`endif
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign mant_norm = wm_q[26:3];
   assign exp_norm  = we_q[7:0];
   assign sign_res  = ws_q;

endmodule
